// File: rtl/calc_input_sequencer_if.sv
// Handshake/data bundle between the calculator input sequencer and its
// surroundings (switches, debouncers, ALU, BCD converter, display path).
interface calc_input_sequencer_if #(
  parameter int N   = 16,
  parameter int OPW = 2
);
  logic [N-1:0]   sw;
  logic           enter_pulse;
  logic           undo_pulse;
  logic [N-1:0]   alu_result;
  logic           conv_idle;
  logic [N-1:0]   op1;
  logic [N-1:0]   op2;
  logic [OPW-1:0] opcode;
  logic [N-1:0]   result_q;
  logic [1:0]     state;
  logic           conv_trigger;
  logic           display_valid;

  modport slave (
    input  sw, enter_pulse, undo_pulse, alu_result, conv_idle,
    output op1, op2, opcode, result_q, state, conv_trigger, display_valid
  );

  modport master (
    output sw, enter_pulse, undo_pulse, alu_result, conv_idle,
    input  op1, op2, opcode, result_q, state, conv_trigger, display_valid
  );
endinterface

// File: rtl/calc_input_sequencer.sv
// Operand/opcode entry sequencer with BCD-conversion handshake.
// Optional macro CHAIN_RESULT_EN: enter in SHOW_RESULT feeds result into op1.
module calc_input_sequencer #(
  parameter int N   = 16,
  parameter int OPW = 2
) (
  input logic                  clk,
  input logic                  rst,
  calc_input_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_OP1    = 2'b00,
    WAIT_OP2    = 2'b01,
    WAIT_OPCODE = 2'b10,
    SHOW_RESULT = 2'b11
  } seq_e;

  typedef enum logic [1:0] {
    C_IDLE = 2'b00,
    C_FIRE = 2'b01,
    C_GAP  = 2'b10,
    C_WAIT = 2'b11
  } conv_e;

  seq_e           state_q, state_d;
  conv_e          conv_q, conv_d;
  logic [N-1:0]   op1_q, op1_d;
  logic [N-1:0]   op2_q, op2_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  logic [N-1:0]   result_q_q, result_q_d;
  logic           cap_q, cap_d;
  logic           pending_q, pending_d;
  logic           enter_acc, undo_acc, set_pend;

  // Simultaneous enter and undo cancel each other out.
  assign enter_acc = bus.enter_pulse & ~bus.undo_pulse;
  assign undo_acc  = bus.undo_pulse  & ~bus.enter_pulse;

  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    opcode_d   = opcode_q;
    result_q_d = result_q_q;
    cap_d      = 1'b0;
    set_pend   = 1'b0;
    case (state_q)
      WAIT_OP1: begin
        if (enter_acc) begin
          op1_d    = bus.sw;
          state_d  = WAIT_OP2;
          set_pend = 1'b1;
        end
      end
      WAIT_OP2: begin
        if (enter_acc) begin
          op2_d    = bus.sw;
          state_d  = WAIT_OPCODE;
          set_pend = 1'b1;
        end else if (undo_acc) begin
          state_d  = WAIT_OP1;
          set_pend = 1'b1;
        end
      end
      WAIT_OPCODE: begin
        // Pending is deferred to the capture cycle so the first conversion
        // already sees the settled ALU result.
        if (enter_acc) begin
          opcode_d = bus.sw[OPW-1:0];
          state_d  = SHOW_RESULT;
          cap_d    = 1'b1;
        end else if (undo_acc) begin
          state_d  = WAIT_OP2;
          set_pend = 1'b1;
        end
      end
      SHOW_RESULT: begin
        if (enter_acc) begin
`ifdef CHAIN_RESULT_EN
          op1_d   = cap_q ? bus.alu_result : result_q_q;
          state_d = WAIT_OP2;
`else
          op1_d   = '0;
          state_d = WAIT_OP1;
`endif
          op2_d      = '0;
          opcode_d   = '0;
          result_q_d = '0;
          set_pend   = 1'b1;
        end else if (undo_acc) begin
          state_d  = WAIT_OPCODE;
          set_pend = 1'b1;
        end else if (cap_q) begin
          result_q_d = bus.alu_result;
          set_pend   = 1'b1;
        end
      end
      default: state_d = WAIT_OP1;
    endcase
  end

  always_comb begin
    conv_d    = conv_q;
    pending_d = pending_q;
    case (conv_q)
      C_IDLE: if (pending_q && bus.conv_idle) conv_d = C_FIRE;
      C_FIRE: begin
        pending_d = 1'b0;
        conv_d    = C_GAP;
      end
      // Converter may not have dropped idle yet; ignore it for one cycle.
      C_GAP:  conv_d = C_WAIT;
      C_WAIT: if (bus.conv_idle) conv_d = C_IDLE;
      default: conv_d = C_IDLE;
    endcase
    if (set_pend) pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_OP1;
      conv_q     <= C_IDLE;
      op1_q      <= '0;
      op2_q      <= '0;
      opcode_q   <= '0;
      result_q_q <= '0;
      cap_q      <= 1'b0;
      pending_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      conv_q     <= conv_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      opcode_q   <= opcode_d;
      result_q_q <= result_q_d;
      cap_q      <= cap_d;
      pending_q  <= pending_d;
    end
  end

  assign bus.op1           = op1_q;
  assign bus.op2           = op2_q;
  assign bus.opcode        = opcode_q;
  assign bus.result_q      = result_q_q;
  assign bus.state         = state_q;
  assign bus.conv_trigger  = (conv_q == C_FIRE);
  assign bus.display_valid = (conv_q == C_IDLE) & ~pending_q & ~cap_q;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Directed bench for calc_input_sequencer: vector table plus hand-written
// corner sequences (reset trigger, capture timing, stuck converter, reset mid-conversion).
module tb_calc_input_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_input_sequencer_if #(.N(16), .OPW(2)) bus ();

  calc_input_sequencer #(.N(16), .OPW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ALU model: 0 and, 1 add, 2 sub, 3 xor
  always_comb begin
    case (bus.opcode)
      2'd0:    bus.alu_result = bus.op1 & bus.op2;
      2'd1:    bus.alu_result = bus.op1 + bus.op2;
      2'd2:    bus.alu_result = bus.op1 - bus.op2;
      default: bus.alu_result = bus.op1 ^ bus.op2;
    endcase
  end

  // Converter model: busy three cycles after each trigger, or while forced.
  int   busy_cnt = 0;
  int   trig_cnt = 0;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    if (bus.conv_trigger) begin
      busy_cnt <= 3;
      trig_cnt <= trig_cnt + 1;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign bus.conv_idle = (busy_cnt == 0) && !force_busy;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dv(input string nm);
    for (int k = 0; k < 80; k++) begin
      if (bus.display_valid) break;
      tick();
    end
    chk({nm, " display_valid settle"}, {31'd0, bus.display_valid}, 32'd1);
  endtask

  task automatic wait_trig(input string nm);
    for (int k = 0; k < 12; k++) begin
      if (bus.conv_trigger) break;
      tick();
    end
    chk({nm, " trigger seen"}, {31'd0, bus.conv_trigger}, 32'd1);
  endtask

  task automatic pulse(input logic [15:0] s, input logic en, input logic un);
    bus.sw          = s;
    bus.enter_pulse = en;
    bus.undo_pulse  = un;
    tick();
    bus.enter_pulse = 1'b0;
    bus.undo_pulse  = 1'b0;
  endtask

  typedef struct {
    logic [15:0] sw;
    logic        en;
    logic        un;
    logic [1:0]  st;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [1:0]  opc;
    logic [15:0] res;
    int          trig;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int t0;
    logic got;
    logic dv_seen;

    tbl[0] = '{16'h1234, 1'b1, 1'b0, 2'd1, 16'h1234, 16'h0000, 2'd0, 16'h0000, 1};
    tbl[1] = '{16'h0011, 1'b1, 1'b0, 2'd2, 16'h1234, 16'h0011, 2'd0, 16'h0000, 1};
    tbl[2] = '{16'h0001, 1'b1, 1'b0, 2'd3, 16'h1234, 16'h0011, 2'd1, 16'h1245, 1};
    tbl[3] = '{16'h0000, 1'b0, 1'b1, 2'd2, 16'h1234, 16'h0011, 2'd1, 16'h1245, 1};
    tbl[4] = '{16'h0000, 1'b0, 1'b1, 2'd1, 16'h1234, 16'h0011, 2'd1, 16'h1245, 1};
    tbl[5] = '{16'hFFFF, 1'b1, 1'b1, 2'd1, 16'h1234, 16'h0011, 2'd1, 16'h1245, 0};
    tbl[6] = '{16'h0022, 1'b1, 1'b0, 2'd2, 16'h1234, 16'h0022, 2'd1, 16'h1245, 1};
    tbl[7] = '{16'h0002, 1'b1, 1'b0, 2'd3, 16'h1234, 16'h0022, 2'd2, 16'h1212, 1};
`ifdef CHAIN_RESULT_EN
    tbl[8] = '{16'h0000, 1'b1, 1'b0, 2'd1, 16'h1212, 16'h0000, 2'd0, 16'h0000, 1};
    tbl[9] = '{16'h0000, 1'b0, 1'b1, 2'd0, 16'h1212, 16'h0000, 2'd0, 16'h0000, 1};
`else
    tbl[8] = '{16'h0000, 1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 2'd0, 16'h0000, 1};
    tbl[9] = '{16'h0000, 1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000, 2'd0, 16'h0000, 0};
`endif

    bus.sw = '0;
    bus.enter_pulse = 1'b0;
    bus.undo_pulse  = 1'b0;

    // Reset state and the single post-reset conversion
    repeat (3) tick();
    chk("rst state", {30'd0, bus.state}, 32'd0);
    chk("rst op1", {16'd0, bus.op1}, 32'd0);
    chk("rst result", {16'd0, bus.result_q}, 32'd0);
    chk("rst trigger", {31'd0, bus.conv_trigger}, 32'd0);
    chk("rst display_valid", {31'd0, bus.display_valid}, 32'd0);
    rst = 1'b0;
    t0  = trig_cnt;
    got = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (bus.conv_trigger) begin
        got = 1'b1;
        break;
      end
    end
    chk("post-reset trigger within 2", {31'd0, got}, 32'd1);
    wait_dv("post-reset");
    chk("post-reset trigger count", trig_cnt - t0, 32'd1);

    // Table-driven transitions
    for (int i = 0; i < 10; i++) begin
      t0 = trig_cnt;
      pulse(tbl[i].sw, tbl[i].en, tbl[i].un);
      chk($sformatf("v%0d state", i), {30'd0, bus.state}, {30'd0, tbl[i].st});
      chk($sformatf("v%0d op1", i), {16'd0, bus.op1}, {16'd0, tbl[i].op1});
      chk($sformatf("v%0d op2", i), {16'd0, bus.op2}, {16'd0, tbl[i].op2});
      chk($sformatf("v%0d opcode", i), {30'd0, bus.opcode}, {30'd0, tbl[i].opc});
      wait_dv($sformatf("v%0d", i));
      chk($sformatf("v%0d result", i), {16'd0, bus.result_q}, {16'd0, tbl[i].res});
      chk($sformatf("v%0d triggers", i), trig_cnt - t0, tbl[i].trig);
    end

    // Result capture lands exactly one cycle after entering SHOW_RESULT
    pulse(16'h0005, 1'b1, 1'b0); wait_dv("cap a");
    pulse(16'h0003, 1'b1, 1'b0); wait_dv("cap b");
    pulse(16'h0003, 1'b1, 1'b0);
    chk("cap state", {30'd0, bus.state}, 32'd3);
    chk("cap result before", {16'd0, bus.result_q}, 32'd0);
    chk("cap display_valid low", {31'd0, bus.display_valid}, 32'd0);
    tick();
    chk("cap result after", {16'd0, bus.result_q}, 32'h0006);
    wait_dv("cap c");

    // Undo in the capture cycle wins; result_q keeps its old value
    pulse(16'h0000, 1'b0, 1'b1); wait_dv("undo a");
    pulse(16'h0000, 1'b1, 1'b0);
    pulse(16'h0000, 1'b0, 1'b1);
    chk("undo-cap state", {30'd0, bus.state}, 32'd2);
    chk("undo-cap result kept", {16'd0, bus.result_q}, 32'h0006);
    chk("undo-cap opcode", {30'd0, bus.opcode}, 32'd0);
    wait_dv("undo b");

    // Converter idle stuck low: one trigger in flight, later ones deferred
    t0 = trig_cnt;
    pulse(16'h0001, 1'b1, 1'b0);
    wait_trig("hold");
    force_busy = 1'b1;
    dv_seen    = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (k == 10) pulse(16'h0009, 1'b1, 1'b0);
      else if (k == 20) pulse(16'h0007, 1'b1, 1'b0);
      else tick();
      if (bus.display_valid) dv_seen = 1'b1;
    end
    chk("hold display_valid never high", {31'd0, dv_seen}, 32'd0);
    chk("hold trigger count", trig_cnt - t0, 32'd1);
`ifdef CHAIN_RESULT_EN
    chk("hold state", {30'd0, bus.state}, 32'd2);
    chk("hold op1", {16'd0, bus.op1}, 32'h0008);
`else
    chk("hold state", {30'd0, bus.state}, 32'd1);
    chk("hold op1", {16'd0, bus.op1}, 32'h0007);
`endif
    force_busy = 1'b0;
    wait_dv("hold release");
    chk("hold total triggers", trig_cnt - t0, 32'd2);

    // Reset while converting in SHOW_RESULT
`ifndef CHAIN_RESULT_EN
    pulse(16'h0001, 1'b1, 1'b0); wait_dv("rst a");
`endif
    pulse(16'h0001, 1'b1, 1'b0);
    chk("pre-rst state", {30'd0, bus.state}, 32'd3);
    wait_trig("pre-rst");
    force_busy = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    force_busy = 1'b0;
    chk("mid-rst state", {30'd0, bus.state}, 32'd0);
    chk("mid-rst op1", {16'd0, bus.op1}, 32'd0);
    chk("mid-rst op2", {16'd0, bus.op2}, 32'd0);
    chk("mid-rst opcode", {30'd0, bus.opcode}, 32'd0);
    chk("mid-rst result", {16'd0, bus.result_q}, 32'd0);
    chk("mid-rst display_valid", {31'd0, bus.display_valid}, 32'd0);
    got = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.conv_trigger) begin
        got = 1'b1;
        break;
      end
    end
    chk("mid-rst fresh trigger", {31'd0, got}, 32'd1);
    wait_dv("mid-rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/calc_input_sequencer.md
Name: calc_input_sequencer

Overview:
- Sequences operand/opcode entry for the 16-bit calculator and produces the `state`, `OP1`, `OP2` and captured result that feed the display path.
- Issues single-cycle conversion triggers to the binary-to-BCD converter and waits for its idle handshake, so the display never shows a stale conversion.
- Sits between the button debouncers / switches and the ALU / display controller.

Parameters:
N, 16, operand and result width
OPW, 2, opcode width (taken from sw[OPW-1:0])

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous reset, active-high
sw  in  N  switch value to be captured
enter_pulse  in  1  one-cycle debounced press, advance
undo_pulse  in  1  one-cycle debounced press, step back
alu_result  in  N  combinational ALU output for (op1, op2, opcode)
conv_idle  in  1  BCD converter idle flag
op1  out  N  captured operand 1
op2  out  N  captured operand 2
opcode  out  OPW  captured operation
result_q  out  N  registered result
state  out  2  00 WAIT_OP1, 01 WAIT_OP2, 10 WAIT_OPCODE, 11 SHOW_RESULT
conv_trigger  out  1  one-cycle start pulse to the converter
display_valid  out  1  high when the converter output matches the current state

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=WAIT_OP1, op1=op2=result_q=0, opcode=0, conv_trigger=0, display_valid=0, pending=1, so one conversion is issued after reset.
- A transition means an accepted enter_pulse or undo_pulse. Both high in the same cycle: both are ignored and no state change occurs.
- enter_pulse transitions:
  - WAIT_OP1: op1<=sw, go to WAIT_OP2.
  - WAIT_OP2: op2<=sw, go to WAIT_OPCODE.
  - WAIT_OPCODE: opcode<=sw[OPW-1:0], go to SHOW_RESULT, set cap.
  - SHOW_RESULT: clear op1, op2, opcode and result_q, go to WAIT_OP1.
- undo_pulse transitions:
  - WAIT_OP2 to WAIT_OP1, WAIT_OPCODE to WAIT_OP2, SHOW_RESULT to WAIT_OPCODE.
  - Captured registers are kept unchanged.
  - In WAIT_OP1, undo_pulse does nothing and does not set pending.
- Result capture: cap delays one cycle so the ALU settles on the new opcode. On the cycle after entering SHOW_RESULT, result_q<=alu_result and cap clears. If undo arrives in that same cycle, undo wins and result_q is not written.
- Conversion handshake:
  - Every accepted transition sets pending. Entry into SHOW_RESULT sets pending only once cap completes.
  - CONV FSM states: IDLE, FIRE, GAP, WAIT.
  - IDLE: if pending and conv_idle, go to FIRE.
  - FIRE: conv_trigger=1 for exactly one cycle, pending cleared, go to GAP.
  - GAP: one cycle in which conv_idle is ignored, go to WAIT.
  - WAIT: when conv_idle=1, go to IDLE.
- display_valid = (CONV FSM in IDLE) and not pending and not cap.
- A transition during FIRE, GAP or WAIT re-sets pending. The next trigger then issues after the current conversion ends; triggers are never overlapped.
- conv_idle stuck low: CONV FSM stays in WAIT, display_valid=0, and input sequencing continues unaffected.
- rst during conversion: the CONV FSM returns to IDLE immediately and pending=1.
- All outputs are registered. op1, op2, opcode and state update on the clk edge that samples the pulse.

Optional Feature:
CHAIN_RESULT_EN
- Defined: enter_pulse in SHOW_RESULT sets op1<=result_q, clears op2 and opcode, and goes to WAIT_OP2 (chained calculation).
- Undefined: behaves as specified above (clear everything, go to WAIT_OP1).

Test Plan:
1. Reset released with conv_idle=1 → conv_trigger pulses once within 2 cycles; state=00; display_valid rises after the converter model's idle returns.
2. sw=0x1234, enter; sw=0x0011, enter; sw=0x0001, enter; ALU model returns 0x1245 → op1=0x1234, op2=0x0011, opcode=1, state=11, result_q=0x1245 exactly 1 cycle after state=11, one trigger per transition.
3. In WAIT_OPCODE press undo → state=01, op1/op2 unchanged. enter_pulse and undo_pulse in the same cycle → no change, no trigger.
4. Hold conv_idle=0 for 50 cycles while issuing 3 enters → only one trigger during the hold, one further trigger after conv_idle=1; display_valid=0 throughout the hold.
5. rst asserted while in WAIT with state=11 → next cycle state=00, all operands 0, then a fresh trigger.
6. With CHAIN_RESULT_EN and result_q=0x1245, enter → state=01, op1=0x1245, op2=0.
